// File: rtl/tri_raster_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tri_raster_ctrl_pkg
// Description : Shared defaults, FSM state encoding and edge-function width.
// Revision    : 1.0 - initial release
// ============================================================================
package tri_raster_ctrl_pkg;

    localparam int DEF_H_RES   = 640;
    localparam int DEF_V_RES   = 480;
    localparam int DEF_COORD_W = 11;
    localparam int DEF_COLOR_W = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SCAN  = 2'd2,
        WRITE = 2'd3
    } state_t;

    // Two (COORD_W+1)-bit signed products and their difference cannot overflow this width.
    function automatic int edge_width(input int coord_w);
        return 2 * coord_w + 3;
    endfunction

    localparam int DEF_EDGE_W = edge_width(DEF_COORD_W);

endpackage
`default_nettype wire

// File: rtl/tri_raster_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : tri_raster_ctrl_if
// Description : Command and pixel-write bundle between host and raster controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface tri_raster_ctrl_if #(
    parameter int COORD_W = 11,
    parameter int COLOR_W = 12
) ();
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_clear;
    logic [COORD_W-1:0] v0x, v0y, v1x, v1y, v2x, v2y;
    logic [COLOR_W-1:0] cmd_color;
    logic               pix_we;
    logic               pix_ready;
    logic [COORD_W-1:0] pix_x, pix_y;
    logic [COLOR_W-1:0] pix_color;
    logic               busy;
    logic               done;

    // Host / test side
    modport master (
        output cmd_valid, cmd_clear, v0x, v0y, v1x, v1y, v2x, v2y, cmd_color, pix_ready,
        input  cmd_ready, pix_we, pix_x, pix_y, pix_color, busy, done
    );

    // Controller side
    modport slave (
        input  cmd_valid, cmd_clear, v0x, v0y, v1x, v1y, v2x, v2y, cmd_color, pix_ready,
        output cmd_ready, pix_we, pix_x, pix_y, pix_color, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/tri_raster_ctrl_edge_fn.sv
`default_nettype none
// ============================================================================
// Module      : tri_raster_ctrl_edge_fn
// Description : Combinational edge function (ax-px)*(by-py) - (bx-px)*(ay-py).
// Revision    : 1.0 - initial release
// ============================================================================
module tri_raster_ctrl_edge_fn
    import tri_raster_ctrl_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W
) (
    input  wire logic [COORD_W-1:0]                  i_ax,
    input  wire logic [COORD_W-1:0]                  i_ay,
    input  wire logic [COORD_W-1:0]                  i_bx,
    input  wire logic [COORD_W-1:0]                  i_by,
    input  wire logic [COORD_W-1:0]                  i_px,
    input  wire logic [COORD_W-1:0]                  i_py,
    output logic signed [edge_width(COORD_W)-1:0]    o_e
);
    localparam int c_EW = edge_width(COORD_W);

    logic signed [COORD_W:0] w_dax, w_day, w_dbx, w_dby;
    logic signed [c_EW-1:0]  w_p0, w_p1;

    assign w_dax = $signed({1'b0, i_ax}) - $signed({1'b0, i_px});
    assign w_day = $signed({1'b0, i_ay}) - $signed({1'b0, i_py});
    assign w_dbx = $signed({1'b0, i_bx}) - $signed({1'b0, i_px});
    assign w_dby = $signed({1'b0, i_by}) - $signed({1'b0, i_py});

    assign w_p0 = c_EW'(w_dax) * c_EW'(w_dby);
    assign w_p1 = c_EW'(w_dbx) * c_EW'(w_day);
    assign o_e  = w_p0 - w_p1;

endmodule
`default_nettype wire

// File: rtl/tri_raster_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tri_raster_ctrl
// Description : Triangle-fill / screen-clear sequencer issuing handshaked pixel writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tri_raster_ctrl
    import tri_raster_ctrl_pkg::*;
#(
    parameter int H_RES   = DEF_H_RES,
    parameter int V_RES   = DEF_V_RES,
    parameter int COORD_W = DEF_COORD_W,
    parameter int COLOR_W = DEF_COLOR_W
) (
    input  wire logic          clk,
    input  wire logic          rst,
    tri_raster_ctrl_if.slave   rif
);
    localparam int                 c_EW   = edge_width(COORD_W);
    localparam logic [COORD_W-1:0] c_XLIM = COORD_W'(H_RES - 1);
    localparam logic [COORD_W-1:0] c_YLIM = COORD_W'(V_RES - 1);

    state_t             r_state, w_state_nxt;
    logic [COORD_W-1:0] r_v0x, r_v0y, r_v1x, r_v1y, r_v2x, r_v2y;
    logic [COLOR_W-1:0] r_color;
    logic               r_clear, r_area_neg, r_done;
    logic [COORD_W-1:0] r_xmin, r_xmax, r_ymin, r_ymax, r_x, r_y;

    logic               w_done_nxt, w_advance, w_empty, w_inside, w_last;
    logic               w_nonneg, w_nonpos;
    logic [COORD_W-1:0] w_xmin, w_xmax, w_ymin, w_ymax, w_xmax_raw, w_ymax_raw;
    logic signed [c_EW-1:0] w_area, w_e0, w_e1, w_e2;

    function automatic logic [COORD_W-1:0] f_min3(input logic [COORD_W-1:0] a, b, c);
        logic [COORD_W-1:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic logic [COORD_W-1:0] f_max3(input logic [COORD_W-1:0] a, b, c);
        logic [COORD_W-1:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    tri_raster_ctrl_edge_fn #(.COORD_W(COORD_W)) u_area (
        .i_ax(r_v0x), .i_ay(r_v0y), .i_bx(r_v1x), .i_by(r_v1y), .i_px(r_v2x), .i_py(r_v2y), .o_e(w_area));
    tri_raster_ctrl_edge_fn #(.COORD_W(COORD_W)) u_e0 (
        .i_ax(r_v0x), .i_ay(r_v0y), .i_bx(r_v1x), .i_by(r_v1y), .i_px(r_x), .i_py(r_y), .o_e(w_e0));
    tri_raster_ctrl_edge_fn #(.COORD_W(COORD_W)) u_e1 (
        .i_ax(r_v1x), .i_ay(r_v1y), .i_bx(r_v2x), .i_by(r_v2y), .i_px(r_x), .i_py(r_y), .o_e(w_e1));
    tri_raster_ctrl_edge_fn #(.COORD_W(COORD_W)) u_e2 (
        .i_ax(r_v2x), .i_ay(r_v2y), .i_bx(r_v0x), .i_by(r_v0y), .i_px(r_x), .i_py(r_y), .o_e(w_e2));

    // Bounding box; the upper bound is clamped to the screen, a fully off-screen box ends up empty.
    assign w_xmax_raw = f_max3(r_v0x, r_v1x, r_v2x);
    assign w_ymax_raw = f_max3(r_v0y, r_v1y, r_v2y);
    assign w_xmin     = r_clear ? '0 : f_min3(r_v0x, r_v1x, r_v2x);
    assign w_ymin     = r_clear ? '0 : f_min3(r_v0y, r_v1y, r_v2y);
    assign w_xmax     = (r_clear || w_xmax_raw > c_XLIM) ? c_XLIM : w_xmax_raw;
    assign w_ymax     = (r_clear || w_ymax_raw > c_YLIM) ? c_YLIM : w_ymax_raw;
    assign w_empty    = !r_clear && (w_area == '0 || w_xmin > w_xmax || w_ymin > w_ymax);

    assign w_nonneg = !w_e0[c_EW-1] && !w_e1[c_EW-1] && !w_e2[c_EW-1];
    assign w_nonpos = (w_e0[c_EW-1] || w_e0 == '0) && (w_e1[c_EW-1] || w_e1 == '0)
                   && (w_e2[c_EW-1] || w_e2 == '0);
    assign w_inside = r_clear || (r_area_neg ? w_nonpos : w_nonneg);
    assign w_last   = (r_x == r_xmax) && (r_y == r_ymax);

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            IDLE:  if (rif.cmd_valid) w_state_nxt = SETUP;
            SETUP: begin
                w_state_nxt = w_empty ? IDLE : SCAN;
                w_done_nxt  = w_empty;
            end
            SCAN: begin
                if (w_inside) begin
                    w_state_nxt = WRITE;
                end else begin
                    w_advance   = 1'b1;
                    w_state_nxt = w_last ? IDLE : SCAN;
                    w_done_nxt  = w_last;
                end
            end
            WRITE: begin
                if (rif.pix_ready) begin
                    w_advance   = 1'b1;
                    w_state_nxt = w_last ? IDLE : SCAN;
                    w_done_nxt  = w_last;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_done     <= 1'b0;
            r_clear    <= 1'b0;
            r_area_neg <= 1'b0;
            r_color    <= '0;
            {r_v0x, r_v0y, r_v1x, r_v1y, r_v2x, r_v2y} <= '0;
            {r_xmin, r_xmax, r_ymin, r_ymax, r_x, r_y} <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            if (r_state == IDLE && rif.cmd_valid) begin
                r_clear <= rif.cmd_clear;
                r_color <= rif.cmd_color;
                {r_v0x, r_v0y, r_v1x, r_v1y, r_v2x, r_v2y} <=
                    {rif.v0x, rif.v0y, rif.v1x, rif.v1y, rif.v2x, rif.v2y};
            end
            if (r_state == SETUP) begin
                r_xmin     <= w_xmin;
                r_xmax     <= w_xmax;
                r_ymin     <= w_ymin;
                r_ymax     <= w_ymax;
                r_x        <= w_xmin;
                r_y        <= w_ymin;
                r_area_neg <= w_area[c_EW-1];
            end else if (w_advance) begin
                // On the last pixel y stays at ymax so counters never leave the box.
                if (r_x == r_xmax) begin
                    r_x <= r_xmin;
                    if (r_y != r_ymax) r_y <= r_y + 1'b1;
                end else begin
                    r_x <= r_x + 1'b1;
                end
            end
        end
    end

    assign rif.cmd_ready = (r_state == IDLE);
    assign rif.busy      = (r_state != IDLE);
    assign rif.pix_we    = (r_state == WRITE);
    assign rif.pix_x     = r_x;
    assign rif.pix_y     = r_y;
    assign rif.pix_color = r_color;
    assign rif.done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_tri_raster_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tri_raster_ctrl
// Description : Randomised bench for tri_raster_ctrl against a pixel-list reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tri_raster_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        cmd_valid, cmd_clear, pix_ready;
    logic [10:0] v0x, v0y, v1x, v1y, v2x, v2y;
    logic [11:0] cmd_color;

    always #5 clk = ~clk;

    tri_raster_ctrl_if #(.COORD_W(11), .COLOR_W(12)) ifb ();
    tri_raster_ctrl_if #(.COORD_W(11), .COLOR_W(12)) ifs ();

    assign ifb.cmd_valid = cmd_valid && !sel;
    assign ifs.cmd_valid = cmd_valid && sel;
    assign {ifb.cmd_clear, ifb.cmd_color, ifb.pix_ready} = {cmd_clear, cmd_color, pix_ready};
    assign {ifs.cmd_clear, ifs.cmd_color, ifs.pix_ready} = {cmd_clear, cmd_color, pix_ready};
    assign {ifb.v0x, ifb.v0y, ifb.v1x, ifb.v1y, ifb.v2x, ifb.v2y} = {v0x, v0y, v1x, v1y, v2x, v2y};
    assign {ifs.v0x, ifs.v0y, ifs.v1x, ifs.v1y, ifs.v2x, ifs.v2y} = {v0x, v0y, v1x, v1y, v2x, v2y};

    tri_raster_ctrl #(.H_RES(640), .V_RES(480), .COORD_W(11), .COLOR_W(12)) dut_big (
        .clk(clk), .rst(rst), .rif(ifb));
    tri_raster_ctrl #(.H_RES(8), .V_RES(4), .COORD_W(11), .COLOR_W(12)) dut_small (
        .clk(clk), .rst(rst), .rif(ifs));

    logic        o_ready, o_busy, o_we, o_done;
    logic [10:0] o_x, o_y;
    logic [11:0] o_col;
    assign o_ready = sel ? ifs.cmd_ready : ifb.cmd_ready;
    assign o_busy  = sel ? ifs.busy      : ifb.busy;
    assign o_we    = sel ? ifs.pix_we    : ifb.pix_we;
    assign o_done  = sel ? ifs.done      : ifb.done;
    assign o_x     = sel ? ifs.pix_x     : ifb.pix_x;
    assign o_y     = sel ? ifs.pix_y     : ifb.pix_y;
    assign o_col   = sel ? ifs.pix_color : ifb.pix_color;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [63:0] exp_q[$];
    int          exp_bbox;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pk(input int x, input int y, input int c);
        return (64'(x) << 32) | (64'(y) << 16) | 64'(c);
    endfunction

    function automatic logic [63:0] obs_word();
        return (64'(o_we) << 63) | pk(int'(o_x), int'(o_y), int'(o_col));
    endfunction

    function automatic longint efn(input longint ax, ay, bx, by, px, py);
        return (ax - px) * (by - py) - (bx - px) * (ay - py);
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Reference: every screen pixel of the clamped box, in raster order, that satisfies the edge rules.
    function automatic void build_exp(input bit clr, input int hres, input int vres,
                                      input int ax, ay, bx, by, cx, cy, input int col);
        int     x0, x1, y0, y1;
        longint area, e0, e1, e2;
        bit     in;
        exp_q.delete();
        exp_bbox = 0;
        area = efn(ax, ay, bx, by, cx, cy);
        if (clr) begin
            x0 = 0; x1 = hres - 1; y0 = 0; y1 = vres - 1;
        end else begin
            x0 = imin(ax, imin(bx, cx)); x1 = imin(imax(ax, imax(bx, cx)), hres - 1);
            y0 = imin(ay, imin(by, cy)); y1 = imin(imax(ay, imax(by, cy)), vres - 1);
            if (area == 0 || x0 > x1 || y0 > y1) return;
        end
        exp_bbox = (x1 - x0 + 1) * (y1 - y0 + 1);
        for (int y = y0; y <= y1; y++) begin
            for (int x = x0; x <= x1; x++) begin
                e0 = efn(ax, ay, bx, by, x, y);
                e1 = efn(bx, by, cx, cy, x, y);
                e2 = efn(cx, cy, ax, ay, x, y);
                in = clr || (area > 0 ? (e0 >= 0 && e1 >= 0 && e2 >= 0)
                                      : (e0 <= 0 && e1 <= 0 && e2 <= 0));
                if (in) exp_q.push_back(pk(x, y, col));
            end
        end
    endfunction

    // mode 0: pix_ready always 1; 1: random ready plus ignored commands; 2: 4-cycle stall on first write.
    task automatic run_cmd(input bit s, input bit clr, input int ax, ay, bx, by, cx, cy,
                           input int col, input int mode, input int rst_at, input string tag);
        int          hres = s ? 8 : 640;
        int          vres = s ? 4 : 480;
        logic [63:0] got_q[$];
        logic [63:0] prev_val = '0;
        bit          prev_hold = 0, done_seen = 0;
        int          cyc = 0, done_at = 0, first_we = 0, oob = 0;

        build_exp(clr, hres, vres, ax, ay, bx, by, cx, cy, col);
        sel = s; cmd_clear = clr; cmd_color = 12'(col);
        {v0x, v0y, v1x, v1y, v2x, v2y} = {11'(ax), 11'(ay), 11'(bx), 11'(by), 11'(cx), 11'(cy)};
        cmd_valid = 1'b1;
        pix_ready = 1'b1;
        chk({tag, "/cmd_ready"}, 64'(o_ready), 64'(1));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_clear = 1'(~clr);
        cmd_color = 12'($urandom);
        {v0x, v0y, v1x, v1y, v2x, v2y} = 66'({$urandom, $urandom, $urandom});

        while (!done_seen && cyc < 12000) begin
            cyc++;
            if (cyc == 1) begin
                chk({tag, "/busy"}, 64'(o_busy), 64'(1));
                chk({tag, "/ready_busy"}, 64'(o_ready), 64'(0));
            end
            if (o_done) begin
                done_seen = 1;
                done_at   = cyc;
                cmd_valid = 1'b0;
            end else begin
                if (prev_hold) chk({tag, "/hold"}, obs_word(), prev_val);
                case (mode)
                    1:       pix_ready = 1'($urandom_range(0, 1));
                    2:       pix_ready = !(o_we && got_q.size() == 0 && first_we < 4);
                    default: pix_ready = 1'b1;
                endcase
                if (o_we && got_q.size() == 0) first_we++;
                if (o_we && rst_at != 0 && got_q.size() == rst_at - 1) begin
                    rst = 1'b1;
                    pix_ready = 1'b0;
                    @(posedge clk); #1;
                    chk({tag, "/rst_we"}, 64'(o_we), 64'(0));
                    chk({tag, "/rst_ready"}, 64'(o_ready), 64'(1));
                    chk({tag, "/rst_done"}, 64'(o_done), 64'(0));
                    chk({tag, "/rst_nwr"}, 64'(got_q.size()), 64'(rst_at - 1));
                    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
                        chk($sformatf("%s/rst_wr%0d", tag, i), got_q[i], exp_q[i]);
                    rst = 1'b0;
                    @(posedge clk); #1;
                    chk({tag, "/rst_nodone"}, 64'(o_done), 64'(0));
                    return;
                end
                if (o_we && pix_ready) begin
                    got_q.push_back(pk(int'(o_x), int'(o_y), int'(o_col)));
                    if (int'(o_x) >= hres || int'(o_y) >= vres) oob++;
                end
                prev_hold = o_we && !pix_ready;
                prev_val  = obs_word();
                if (mode == 1) begin
                    cmd_valid = 1'($urandom_range(0, 1));
                    cmd_color = 12'($urandom);
                    v0x = 11'($urandom);
                end
                @(posedge clk); #1;
            end
        end
        cmd_valid = 1'b0;

        chk({tag, "/done_seen"}, 64'(done_seen), 64'(1));
        chk({tag, "/nwr"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s/wr%0d", tag, i), got_q[i], exp_q[i]);
        chk({tag, "/oob"}, 64'(oob), 64'(0));
        if (mode == 0)
            chk({tag, "/latency"}, 64'(done_at),
                64'(exp_bbox == 0 ? 2 : 2 + exp_bbox + exp_q.size()));
        if (mode == 2) chk({tag, "/stall_cycles"}, 64'(first_we), 64'(5));
        @(posedge clk); #1;
        chk({tag, "/done_pulse"}, 64'(o_done), 64'(0));
        chk({tag, "/idle_ready"}, 64'(o_ready), 64'(1));
        chk({tag, "/idle_busy"}, 64'(o_busy), 64'(0));
    endtask

    initial begin
        int base_x, base_y, lim, s, clr;
        rst = 1'b1; sel = 1'b0; cmd_valid = 1'b0; cmd_clear = 1'b0; pix_ready = 1'b0;
        cmd_color = '0;
        {v0x, v0y, v1x, v1y, v2x, v2y} = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset/cmd_ready", 64'(o_ready), 64'(1));
        chk("reset/busy", 64'(o_busy), 64'(0));
        chk("reset/pix_we", 64'(o_we), 64'(0));
        chk("reset/done", 64'(o_done), 64'(0));
        chk("reset/pix_xyc", pk(int'(o_x), int'(o_y), int'(o_col)), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        run_cmd(0, 0, 0, 0, 2, 0, 0, 2, 'h00F, 0, 0, "tri_ccw");
        run_cmd(0, 0, 0, 0, 0, 2, 2, 0, 'h00F, 0, 0, "tri_cw");
        run_cmd(0, 0, 0, 0, 5, 5, 10, 10, 'h123, 0, 0, "collinear");
        run_cmd(0, 0, 0, 0, 2, 0, 0, 2, 'h00F, 2, 0, "stall");
        run_cmd(1, 1, 0, 0, 0, 0, 0, 0, 'hFFF, 0, 0, "clear");
        run_cmd(1, 0, 6, 1, 700, 1, 6, 3, 'h0A5, 0, 0, "clamp");
        run_cmd(0, 0, 650, 10, 700, 10, 660, 40, 'h321, 0, 0, "offscreen");
        run_cmd(0, 0, 0, 0, 2, 0, 0, 2, 'h00F, 0, 3, "mid_rst");
        run_cmd(0, 0, 0, 0, 2, 0, 0, 2, 'h00F, 0, 0, "after_rst");
        run_cmd(1, 1, 0, 0, 0, 0, 0, 0, 'h5A5, 1, 0, "clear_rnd");

        for (int k = 0; k < 12; k++) begin
            s   = int'($urandom_range(0, 2) == 0);
            clr = int'(s == 1 && $urandom_range(0, 3) == 0);
            if (s == 1) begin
                base_x = 0; base_y = 0; lim = 12;
            end else if ($urandom_range(0, 2) == 0) begin
                base_x = 610; base_y = 455; lim = 45;
            end else begin
                base_x = int'($urandom_range(0, 560)); base_y = int'($urandom_range(0, 420)); lim = 45;
            end
            run_cmd(s[0], clr[0],
                    base_x + int'($urandom_range(0, lim)), base_y + int'($urandom_range(0, lim)),
                    base_x + int'($urandom_range(0, lim)), base_y + int'($urandom_range(0, lim)),
                    base_x + int'($urandom_range(0, lim)), base_y + int'($urandom_range(0, lim)),
                    int'($urandom_range(0, 4095)), int'($urandom_range(0, 1)), 0,
                    $sformatf("rnd%0d", k));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
